// File: rtl/fsm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// fsm_ctrl_pkg : shared types and constants for the table-driven controller
// Revision     : 1.0
// ============================================================================
package fsm_ctrl_pkg;

  localparam int STATE_W   = 3;
  localparam int OUT_W     = 3;
  localparam int ENTRY_W   = STATE_W + OUT_W;
  localparam int TBL_DEPTH = 16;
  localparam int TBL_AW    = 4;

  // Entry layout: {next_state, out}
  localparam int NS_HI  = 5;
  localparam int NS_LO  = 3;
  localparam int OUT_HI = 2;
  localparam int OUT_LO = 0;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'd0,
    CTRL_LOAD  = 2'd1,
    CTRL_RUN   = 2'd2,
    CTRL_FAULT = 2'd3
  } ctrl_e;

  function automatic logic [STATE_W-1:0] entry_next(input logic [ENTRY_W-1:0] e);
    return e[NS_HI:NS_LO];
  endfunction

  function automatic logic [OUT_W-1:0] entry_out(input logic [ENTRY_W-1:0] e);
    return e[OUT_HI:OUT_LO];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_table_ram.sv
`default_nettype none
// ============================================================================
// fsm_table_ram : 16x6 transition table, sync write, async read, no reset
// Revision      : 1.0
// ============================================================================
module fsm_table_ram
  import fsm_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [TBL_AW-1:0]  waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [TBL_AW-1:0]  raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] r_mem [TBL_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fsm_table_ctrl.sv
`default_nettype none
// ============================================================================
// fsm_table_ctrl : programmable table-driven sequence machine with load port,
//                  run/stop/step control and sticky illegal-transition trap
// Revision       : 1.0
// ============================================================================
module fsm_table_ctrl
  import fsm_ctrl_pkg::*;
#(
  parameter logic [STATE_W-1:0] INIT_STATE = 3'd2,
  parameter logic [7:0]         LEGAL_MASK = 8'b0011_1110
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [ENTRY_W-1:0] cfg_data,
  input  logic               run_start,
  input  logic               run_stop,
  input  logic               step,
  input  logic               a,
  output logic [STATE_W-1:0] state_q,
  output logic [OUT_W-1:0]   saida,
  output logic               loaded,
  output logic               fault
);

  ctrl_e               r_ctrl, w_ctrl_d;
  logic [TBL_AW-1:0]   r_wr_ptr, w_wr_ptr_d;
  logic [STATE_W-1:0]  r_state, w_state_d;
  logic [OUT_W-1:0]    r_saida, w_saida_d;
  logic                r_loaded, w_loaded_d;
  logic                r_fault, w_fault_d;
  logic                w_we;
  logic                w_accept;
  logic                w_legal;
  logic [TBL_AW-1:0]   w_raddr;
  logic [ENTRY_W-1:0]  w_entry;
  logic [STATE_W-1:0]  w_ns;

  assign w_raddr  = {a, r_state};
  assign w_ns     = entry_next(w_entry);
  assign w_legal  = LEGAL_MASK[w_ns];
  assign w_accept = cfg_valid & cfg_ready;

  fsm_table_ram u_table (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_wr_ptr),
    .wdata (cfg_data),
    .raddr (w_raddr),
    .rdata (w_entry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl <= CTRL_IDLE;
    end else begin
      r_ctrl <= w_ctrl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_state  <= INIT_STATE;
      r_saida  <= '0;
      r_loaded <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_d;
      r_state  <= w_state_d;
      r_saida  <= w_saida_d;
      r_loaded <= w_loaded_d;
      r_fault  <= w_fault_d;
    end
  end

  always_comb begin
    w_ctrl_d   = r_ctrl;
    w_wr_ptr_d = r_wr_ptr;
    w_state_d  = r_state;
    w_saida_d  = r_saida;
    w_loaded_d = r_loaded;
    w_fault_d  = r_fault;
    w_we       = 1'b0;
    case (r_ctrl)
      CTRL_IDLE: begin
        if (load_start) begin
          w_ctrl_d   = CTRL_LOAD;
          w_wr_ptr_d = '0;
          w_loaded_d = 1'b0;
        end else if (run_start && r_loaded) begin
          w_ctrl_d  = CTRL_RUN;
          w_state_d = INIT_STATE;
          w_saida_d = '0;
        end
      end
      CTRL_LOAD: begin
        // An abort drops the same-cycle beat so a partial table is never flagged loaded.
        if (run_stop) begin
          w_ctrl_d   = CTRL_IDLE;
          w_loaded_d = 1'b0;
        end else if (w_accept) begin
          w_we       = 1'b1;
          w_wr_ptr_d = r_wr_ptr + 1'b1;
          if (r_wr_ptr == TBL_AW'(TBL_DEPTH - 1)) begin
            w_ctrl_d   = CTRL_IDLE;
            w_loaded_d = 1'b1;
          end
        end
      end
      CTRL_RUN: begin
        if (run_stop) begin
          w_ctrl_d = CTRL_IDLE;
        end else if (step) begin
          if (w_legal) begin
            w_state_d = w_ns;
            w_saida_d = entry_out(w_entry);
          end else begin
            w_ctrl_d  = CTRL_FAULT;
            w_fault_d = 1'b1;
          end
        end
      end
      CTRL_FAULT: begin
        if (load_start) begin
          w_ctrl_d   = CTRL_LOAD;
          w_fault_d  = 1'b0;
          w_wr_ptr_d = '0;
          w_loaded_d = 1'b0;
        end
      end
      default: begin
        w_ctrl_d = CTRL_IDLE;
      end
    endcase
  end

  assign cfg_ready = (r_ctrl == CTRL_LOAD);
  assign state_q   = r_state;
  assign saida     = r_saida;
  assign loaded    = r_loaded;
  assign fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fsm_table_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fsm_table_ctrl : directed scenarios plus random traffic vs. a reference model
// Revision          : 1.0
// ============================================================================
module tb_fsm_table_ctrl;

  logic       clk = 1'b0;
  logic       reset, load_start, cfg_valid, cfg_ready, run_start, run_stop, step, a;
  logic       loaded, fault;
  logic [5:0] cfg_data;
  logic [2:0] state_q, saida;

  always #5 clk = ~clk;

  fsm_table_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .run_start  (run_start),
    .run_stop   (run_stop),
    .step       (step),
    .a          (a),
    .state_q    (state_q),
    .saida      (saida),
    .loaded     (loaded),
    .fault      (fault)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: controller mode, table contents and visible registers
  localparam int MD_IDLE = 0, MD_LOAD = 1, MD_RUN = 2, MD_FAULT = 3;
  int         m_mode;
  int         m_wr;
  int         m_state;
  int         m_saida;
  bit         m_loaded;
  bit         m_fault;
  logic [5:0] m_tbl [16];
  logic [5:0] prog  [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit ls, cv, input logic [5:0] cd,
                            input bit rs, rp, st, aa, rr);
    int e, ns;
    if (rr) begin
      m_mode = MD_IDLE; m_wr = 0; m_state = 2; m_saida = 0; m_loaded = 0; m_fault = 0;
      return;
    end
    case (m_mode)
      MD_IDLE: begin
        if (ls) begin m_mode = MD_LOAD; m_wr = 0; m_loaded = 0; end
        else if (rp && m_loaded) begin m_mode = MD_RUN; m_state = 2; m_saida = 0; end
      end
      MD_LOAD: begin
        if (rs) begin m_mode = MD_IDLE; m_loaded = 0; end
        else if (cv) begin
          m_tbl[m_wr] = cd;
          if (m_wr == 15) begin m_mode = MD_IDLE; m_loaded = 1; end
          m_wr = (m_wr + 1) % 16;
        end
      end
      MD_RUN: begin
        if (rs) m_mode = MD_IDLE;
        else if (st) begin
          e  = int'(m_tbl[(aa ? 8 : 0) + m_state]);
          ns = e / 8;
          if (ns >= 1 && ns <= 5) begin m_state = ns; m_saida = e % 8; end
          else begin m_mode = MD_FAULT; m_fault = 1; end
        end
      end
      default: begin
        if (ls) begin m_mode = MD_LOAD; m_fault = 0; m_wr = 0; m_loaded = 0; end
      end
    endcase
  endtask

  // One clock: apply inputs, advance the model at the edge, compare just after it.
  task automatic cyc(input bit ls, cv, input logic [5:0] cd,
                     input bit rs, rp, st, aa, rr);
    load_start = ls; cfg_valid = cv; cfg_data = cd; run_stop = rs;
    run_start = rp; step = st; a = aa; reset = rr;
    @(posedge clk);
    model_step(ls, cv, cd, rs, rp, st, aa, rr);
    #1;
    check("state_q",   state_q,   m_state);
    check("saida",     saida,     m_saida);
    check("loaded",    loaded,    m_loaded);
    check("fault",     fault,     m_fault);
    check("cfg_ready", cfg_ready, (m_mode == MD_LOAD));
  endtask

  task automatic idle();
    cyc(0, 0, 6'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_prog();
    cyc(1, 0, 6'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, prog[i], 0, 0, 0, 0, 0);
  endtask

  task automatic set_good_prog();
    for (int i = 0; i < 16; i++) prog[i] = 6'h10;
    prog[1] = 6'h1b; prog[2] = 6'h08; prog[3] = 6'h22; prog[4] = 6'h14; prog[5] = 6'h1d;
    prog[9] = 6'h2b; prog[10] = 6'h20; prog[11] = 6'h22; prog[12] = 6'h0c; prog[13] = 6'h1d;
  endtask

  function automatic logic [5:0] rand_entry();
    logic [2:0] ns, o;
    o = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 9) < 8) ns = 3'($urandom_range(1, 5));
    else ns = 3'($urandom_range(0, 7));
    return {ns, o};
  endfunction

  initial begin
    int k;
    for (int i = 0; i < 16; i++) m_tbl[i] = 6'h0;
    cyc(0, 0, 6'h0, 0, 0, 0, 0, 1);
    cyc(0, 0, 6'h0, 0, 0, 0, 0, 1);
    check("rst_state_q", state_q, 3'd2);
    check("rst_saida", saida, 3'd0);
    check("rst_loaded", loaded, 1'b0);
    check("rst_cfg_ready", cfg_ready, 1'b0);

    // Load and run the reference program
    set_good_prog();
    load_prog();
    check("t1_loaded", loaded, 1'b1);
    cyc(0, 0, 6'h0, 0, 1, 0, 0, 0);
    cyc(0, 0, 6'h0, 0, 0, 1, 0, 0);
    check("t1_s1", state_q, 3'd1); check("t1_o1", saida, 3'd0);
    cyc(0, 0, 6'h0, 0, 0, 1, 0, 0);
    check("t1_s2", state_q, 3'd3); check("t1_o2", saida, 3'd3);
    cyc(0, 0, 6'h0, 0, 0, 1, 1, 0);
    check("t1_s3", state_q, 3'd4); check("t1_o3", saida, 3'd2);
    check("t1_loaded_run", loaded, 1'b1);
    cyc(0, 0, 6'h0, 1, 0, 0, 0, 0);

    // Stalled load: valid every other cycle, garbage while invalid
    cyc(1, 0, 6'h0, 0, 0, 0, 0, 0);
    k = 0;
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 1) begin cyc(0, 1, prog[k], 0, 0, 0, 0, 0); k++; end
      else cyc(0, 0, 6'($urandom_range(0, 63)), 0, 0, 0, 0, 0);
      if (i == 29) check("t2_loaded_early", loaded, 1'b0);
      if (i < 31) check("t2_ready", cfg_ready, 1'b1);
    end
    check("t2_loaded", loaded, 1'b1);
    cyc(0, 0, 6'h0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 6'h0, 0, 0, 1, 1'($urandom_range(0, 1)), 0);
    cyc(0, 0, 6'h0, 1, 0, 0, 0, 0);

    // Abort after 7 beats, then run_start must be refused
    cyc(0, 0, 6'h0, 0, 0, 0, 0, 1);
    cyc(1, 0, 6'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, prog[i], 0, 0, 0, 0, 0);
    cyc(0, 1, 6'h38, 1, 0, 0, 0, 0);
    check("t3_loaded", loaded, 1'b0);
    check("t3_ready", cfg_ready, 1'b0);
    cyc(0, 0, 6'h0, 0, 1, 0, 0, 0);
    cyc(0, 0, 6'h0, 0, 0, 1, 0, 0);
    check("t3_state", state_q, 3'd2);

    // Illegal next state traps into FAULT
    prog[2] = 6'h38;
    load_prog();
    cyc(0, 0, 6'h0, 0, 1, 0, 0, 0);
    cyc(0, 0, 6'h0, 0, 0, 1, 0, 0);
    check("t4_fault", fault, 1'b1);
    check("t4_state", state_q, 3'd2);
    check("t4_saida", saida, 3'd0);
    cyc(0, 0, 6'h0, 0, 1, 1, 0, 0);
    cyc(0, 0, 6'h0, 0, 0, 1, 1, 0);
    check("t4_hold", state_q, 3'd2);
    cyc(1, 0, 6'h0, 0, 0, 0, 0, 0);
    check("t4_clear", fault, 1'b0);
    check("t4_ready", cfg_ready, 1'b1);
    set_good_prog();
    for (int i = 0; i < 16; i++) cyc(0, 1, prog[i], 0, 0, 0, 0, 0);

    // Simultaneous events
    cyc(0, 0, 6'h0, 0, 1, 0, 0, 0);
    cyc(0, 0, 6'h0, 0, 0, 1, 0, 0);
    cyc(0, 0, 6'h0, 1, 0, 1, 0, 0);
    check("t5_stop_wins", state_q, 3'd1);
    cyc(1, 0, 6'h0, 0, 1, 0, 0, 0);
    check("t5_load_wins", cfg_ready, 1'b1);
    for (int i = 0; i < 16; i++) cyc(0, 1, prog[i], 0, 0, 0, 0, 0);

    // Reset mid-load and mid-run
    cyc(1, 0, 6'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, prog[i], 0, 0, 0, 0, 0);
    cyc(0, 1, prog[8], 0, 0, 0, 0, 1);
    check("t6_ready", cfg_ready, 1'b0);
    check("t6_loaded", loaded, 1'b0);
    load_prog();
    check("t6_reload", loaded, 1'b1);
    cyc(0, 0, 6'h0, 0, 1, 0, 0, 0);
    cyc(0, 0, 6'h0, 0, 0, 1, 0, 0);
    cyc(0, 0, 6'h0, 0, 0, 1, 0, 0);
    cyc(0, 0, 6'h0, 0, 0, 1, 0, 1);
    check("t6_run_state", state_q, 3'd2);
    check("t6_run_saida", saida, 3'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), rand_entry(),
          ($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 1) == 1), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 499) == 0));
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
